// File: rtl/sopc_run_ctrl.sv
// Reset/run sequencer for a small SOPC: holds all channels in reset, releases
// them one by one with a fixed stagger, then times the run phase until a halt
// request or the run limit ends it.
module sopc_run_ctrl #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned STAGGER     = 1,
    parameter int unsigned RUN_LIMIT   = 50,
    parameter int unsigned CW          = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           halt_req,
    output logic [NCH-1:0] chan_rst,
    output logic           running,
    output logic           done,
    output logic           timeout,
    output logic [CW-1:0]  run_cnt
);

    localparam int unsigned IW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned HOLD_LAST  = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int unsigned STG_LAST   = (STAGGER > 0) ? STAGGER - 1 : 0;
    localparam int unsigned LIM_LAST   = (RUN_LIMIT > 0) ? RUN_LIMIT - 1 : 0;
    // A single channel or zero stagger skips the release phase entirely.
    localparam bit          DIRECT_RUN = (STAGGER == 0) || (NCH == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_STOP
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [NCH-1:0] chan_rst_q, chan_rst_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic [CW-1:0]  run_cnt_q, run_cnt_d;
    logic [CW-1:0]  run_cnt_inc;

    // Saturating run-cycle increment.
    assign run_cnt_inc = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CW'(1);

    // State and output registers; reset forces the idle/all-in-reset picture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            chan_rst_q <= '1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            run_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            chan_rst_q <= chan_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    // Next-state and next-output logic for the sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        chan_rst_d = chan_rst_q;
        running_d  = running_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        run_cnt_d  = run_cnt_q;

        case (state_q)
            S_IDLE, S_STOP: begin
                chan_rst_d = '1;
                running_d  = 1'b0;
                if (start) begin
                    state_d   = S_HOLD;
                    cnt_d     = '0;
                    idx_d     = '0;
                    run_cnt_d = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (halt_req) begin
                    state_d    = S_STOP;
                    chan_rst_d = '1;
                    done_d     = 1'b1;
                    timeout_d  = 1'b0;
                end else if (cnt_q == CW'(HOLD_LAST)) begin
                    cnt_d = '0;
                    if (DIRECT_RUN) begin
                        chan_rst_d = '0;
                        running_d  = 1'b1;
                        state_d    = S_RUN;
                    end else begin
                        chan_rst_d    = '1;
                        chan_rst_d[0] = 1'b0;
                        idx_d         = IW'(1);
                        state_d       = S_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_RELEASE: begin
                if (halt_req) begin
                    state_d    = S_STOP;
                    chan_rst_d = '1;
                    done_d     = 1'b1;
                    timeout_d  = 1'b0;
                end else if (cnt_q == CW'(STG_LAST)) begin
                    cnt_d = '0;
                    for (int k = 0; k < NCH; k++) begin
                        if (IW'(k) == idx_q) chan_rst_d[k] = 1'b0;
                    end
                    if (idx_q == IW'(NCH - 1)) begin
                        state_d   = S_RUN;
                        running_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_RUN: begin
                run_cnt_d = run_cnt_inc;
                if (halt_req) begin
                    state_d    = S_STOP;
                    chan_rst_d = '1;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b0;
                end else if ((RUN_LIMIT != 0) && (run_cnt_q == CW'(LIM_LAST))) begin
                    state_d    = S_STOP;
                    chan_rst_d = '1;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                chan_rst_d = '1;
                running_d  = 1'b0;
            end
        endcase
    end

    assign chan_rst = chan_rst_q;
    assign running  = running_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign run_cnt  = run_cnt_q;

endmodule

// File: doc/sopc_run_ctrl.md
SOPC_RUN_CTRL -- requirements
Module: sopc_run_ctrl

Interface
REQ-001 The block SHALL have parameter NCH, default 2, meaning number of independently reset core/peripheral channels (1..8).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 10, meaning cycles all channels are held in reset after start (1..2^CW-1).
REQ-003 The block SHALL have parameter STAGGER, default 1, meaning cycles between successive channel reset releases (0 = all channels release together).
REQ-004 The block SHALL have parameter RUN_LIMIT, default 50, meaning maximum run cycles before forced stop (0 = unlimited).
REQ-005 The block SHALL have parameter CW, default 16, meaning width of internal counters and of run_cnt.
REQ-006 The block SHALL have port clk, input, 1, meaning the single system clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-008 The block SHALL have port start, input, 1, meaning a 1-cycle pulse that begins a reset/run sequence.
REQ-009 The block SHALL have port halt_req, input, 1, meaning a request from the running system to stop.
REQ-010 The block SHALL have port chan_rst, output, NCH, meaning per-channel active-high reset (1 = channel held in reset).
REQ-011 The block SHALL have port running, output, 1, meaning all channels are released and the run phase is active.
REQ-012 The block SHALL have port done, output, 1, meaning the sequence ended (sticky).
REQ-013 The block SHALL have port timeout, output, 1, meaning the sequence ended because RUN_LIMIT was reached (sticky).
REQ-014 The block SHALL have port run_cnt, output, CW, meaning cycles spent in RUN.

Function
REQ-015 States SHALL be IDLE, HOLD, RELEASE, RUN, STOP; all outputs registered.
REQ-016 IDLE: chan_rst all 1, running 0; start=1 -> HOLD, clearing hold counter, run_cnt, done, timeout.
REQ-017 HOLD SHALL last exactly HOLD_CYCLES cycles with chan_rst all 1; on the exit edge chan_rst[0] goes 0.
REQ-018 If STAGGER=0, the HOLD exit edge SHALL clear all chan_rst bits and enter RUN directly.
REQ-019 RELEASE: chan_rst[k] SHALL go 0 exactly k*STAGGER cycles after chan_rst[0]; bits, once cleared, stay 0 until STOP/IDLE.
REQ-020 On the edge that clears chan_rst[NCH-1] the state SHALL become RUN and running SHALL go 1 on the same edge; NCH=1 behaves as STAGGER=0.
REQ-021 RUN: run_cnt SHALL increment by 1 each cycle, saturating at 2^CW-1.
REQ-022 RUN with halt_req=1 SHALL go to STOP next edge: done=1, timeout=0.
REQ-023 RUN with RUN_LIMIT!=0 and run_cnt==RUN_LIMIT-1 SHALL go to STOP next edge: done=1, timeout=1, run_cnt=RUN_LIMIT.
REQ-024 Simultaneous halt_req and limit SHALL be treated as halt (timeout=0).
REQ-025 halt_req in HOLD or RELEASE SHALL go to STOP next edge with done=1, timeout=0, run_cnt=0.
REQ-026 STOP: chan_rst all 1, running 0, done/timeout/run_cnt held; start=1 -> HOLD as from IDLE.
REQ-027 start SHALL be ignored in HOLD, RELEASE and RUN.
REQ-028 halt_req SHALL be ignored in IDLE and STOP.

Reset
REQ-029 rst=0 SHALL immediately, independent of clk, force IDLE, chan_rst all 1, running 0, done 0, timeout 0, run_cnt 0.
REQ-030 Reset asserted mid-sequence (any state) SHALL abort it with the REQ-029 values; no start is remembered across reset.
REQ-031 After rst rises, no state change SHALL occur before the first start pulse.

Verification
REQ-032 Defaults, start at cycle 0 -> chan_rst=2'b11 for cycles 1-10, 2'b10 at cycle 10 edge, 2'b00 and running=1 at cycle 11.
REQ-033 Defaults, no halt -> done=1, timeout=1, run_cnt=50 at 50 cycles after running rose; chan_rst=2'b11.
REQ-034 Defaults, halt_req pulsed at run_cnt=20 -> next edge done=1, timeout=0, run_cnt frozen at 21, running 0.
REQ-035 NCH=4, STAGGER=3 -> chan_rst 1110, 1100, 1000, 0000 at 0, 3, 6, 9 cycles after HOLD exit; start pulses during this ignored.
REQ-036 rst=0 driven asynchronously mid-RUN (between edges) -> outputs take REQ-029 values before next clk edge; second start after release restarts cleanly.
REQ-037 RUN_LIMIT=0 with CW=4 -> run_cnt saturates at 15, no timeout; halt_req and RUN_LIMIT hit same cycle -> timeout=0.
